rim_solver_param: RTL and testbench
===================================

# rim_solver_param

Parametrised rat-in-maze solver, successor to the fixed 8x8 solver. It loads an N x N binary maze one row per cycle and searches for a path from (0,0) to (N-1,N-1). The search moves down or right only, one step per cycle, and uses a depth-first stack to backtrack. It then streams the path cells, or raises a one-cycle failure indication when no path exists. It sits between the maze source and the path consumer and uses the same in_valid/out_valid streaming handshake.

## Interface
- N, default 8: maze dimension, legal 2..16. Derived: W = clog2(N); PATH_LEN = 2N-1; STACK_DEPTH = 2N-2.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  maze row valid
- maze  in  N  one row; maze[c] = column c; 1 = open, 0 = wall
- out_valid  out  1  path cell valid, or failure pulse
- out_row  out  W  path cell row
- out_col  out  W  path cell column
- out_fail  out  1  qualifies out_valid: no path exists
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, SOLVE, OUTPUT, FAIL.
- LOAD
  - Each in_valid cycle writes maze into row row_cnt; row_cnt starts at 0.
  - A cycle with in_valid low holds row_cnt; loading pauses, not aborts.
  - After row N-1 is written, go to SOLVE with cur = (0,0), path index idx = 0, stack empty.
- SOLVE, one action per cycle:
  - Mark cur as wall.
  - d_ok = r<N-1 and cell(r+1,c) open.
  - r_ok = c<N-1 and cell(r,c+1) open.
- Action selection:
  - If cur = (N-1,N-1): record path[idx] = cur and go to OUTPUT.
  - Else if d_ok or r_ok: record path[idx] = cur, idx++. Move down if d_ok, else right (down has priority).
  - If d_ok and r_ok, additionally push (r,c,idx) before the move.
  - Else (dead end): if the stack is non-empty, pop and restore cur and idx. If it is empty, go to FAIL.
- Start cell (0,0) being a wall: it is a dead end on the first SOLVE cycle with an empty stack, so go to FAIL.
- Stack: STACK_DEPTH entries of {row, col, idx}. Pushes along one path are at most 2N-2, so overflow cannot occur and needs no handling. Push and pop never occur in the same cycle.
- A restored branch cell's down neighbour is already walled, so the search resumes rightward.
- OUTPUT: PATH_LEN consecutive cycles with out_valid = 1, presenting path[0]..path[PATH_LEN-1] in order. Then go to IDLE.
- FAIL: exactly one cycle with out_valid = 1, out_fail = 1 and out_row/out_col = 0. Then go to IDLE.
- Abort: in_valid high while in SOLVE, OUTPUT or FAIL:
  - Outputs clear to 0 that cycle.
  - The stack clears.
  - The current maze row is taken as row 0 of a new load; state becomes LOAD.
- in_valid in IDLE starts LOAD with that row as row 0.

## Timing
- Reset values: out_valid 0, out_fail 0, out_row 0, out_col 0, busy 0; state IDLE; row_cnt 0; stack empty.
- All outputs are registered.
- busy rises the cycle after the first in_valid and falls the cycle after the last out_valid.
- The first SOLVE cycle is the cycle after the Nth row is accepted.
- The first out_valid is the cycle after the goal cell is recorded. Cell outputs are contiguous; no gaps.
- SOLVE length: at most 2*N*N cycles. Each cell is visited at most once and each pop matches an earlier push.
- Open maze (no backtracking): SOLVE lasts exactly 2N-1 cycles.
- out_valid is 0 in every cycle outside OUTPUT and FAIL.

## Test plan
- Open maze, N=8, all rows 8'hFF.
  - Required: after 15 SOLVE cycles, 15 out_valid cycles: (0,0),(1,0)..(7,0),(7,1)..(7,7); out_fail 0.
- Backtrack maze, N=8, row0 = 8'hFF, rows 1-4 = 8'h81, rows 5-7 = 8'h80.
  - Search reaches dead end (4,0), pops to (0,0), then goes right.
  - Required output: (0,0),(0,1)..(0,7),(1,7)..(7,7).
- No path, N=8: all rows 8'hFF except row 4 = 8'h00.
  - Required: exactly one out_valid with out_fail = 1 and out_row = out_col = 0; busy then falls.
- Blocked start, N=8: row0 = 8'hFE, others 8'hFF.
  - Required: FAIL pulse on the cycle after the first SOLVE cycle.
- Abort and gaps:
  - Assert in_valid mid-SOLVE: outputs stay 0 and a new 8-row load completes normally.
  - Insert in_valid gaps during LOAD: result is identical to a contiguous load.
- Parameter N=4, all rows 4'hF.
  - Required: 7 cells (0,0),(1,0),(2,0),(3,0),(3,1),(3,2),(3,3); out_row/out_col are 2 bits wide.

Source files
------------

// File: rtl/rim_solver_param_if.sv
// -----------------------------------------------------------------------------
// rim_solver_param_if
// Streaming bus between the maze source, the solver and the path consumer.
//   in_valid  : maze row valid (source -> solver)
//   maze[N]   : one maze row, bit c = column c, 1 = open
//   out_valid : path cell valid, or failure pulse (solver -> consumer)
//   out_row   : path cell row    (W bits)
//   out_col   : path cell column (W bits)
//   out_fail  : qualifies out_valid, no path exists
//   busy      : solver is not idle
// master = source/consumer side, slave = solver side.
// -----------------------------------------------------------------------------
interface rim_solver_param_if #(
   parameter int N = 8
) ();
   localparam int W = $clog2(N);

   logic         in_valid;
   logic [N-1:0] maze;
   logic         out_valid;
   logic [W-1:0] out_row;
   logic [W-1:0] out_col;
   logic         out_fail;
   logic         busy;

   modport master (
      output in_valid, maze,
      input  out_valid, out_row, out_col, out_fail, busy
   );

   modport slave (
      input  in_valid, maze,
      output out_valid, out_row, out_col, out_fail, busy
   );
endinterface

// File: rtl/rim_solver_param.sv
// -----------------------------------------------------------------------------
// rim_solver_param
// Loads an N x N binary maze one row per in_valid cycle, searches a down/right
// path from (0,0) to (N-1,N-1) with a depth-first stack (down preferred), then
// streams the 2N-1 path cells or emits a single failure pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rim_solver_param_if.slave (in_valid, maze, out_valid, out_row,
//           out_col, out_fail, busy); all outputs are registered.
// -----------------------------------------------------------------------------
module rim_solver_param #(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   rim_solver_param_if.slave bus
);
   localparam int W           = $clog2(N);
   localparam int PATH_LEN    = 2*N - 1;
   localparam int STACK_DEPTH = 2*N - 2;
   localparam int IW          = $clog2(2*N);
   localparam logic [W-1:0]  LAST = W'(N - 1);
   localparam logic [IW-1:0] PLEN = IW'(PATH_LEN);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SOLVE, S_OUTPUT, S_FAIL} state_t;

   typedef struct packed {
      logic [W-1:0]  r;
      logic [W-1:0]  c;
      logic [IW-1:0] idx;
   } entry_t;

   state_t        state_q, state_d;
   logic [W-1:0]  row_cnt_q, row_cnt_d;
   logic [W-1:0]  r_q, r_d, c_q, c_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] sp_q, sp_d;
   logic [IW-1:0] oidx_q, oidx_d;
   logic          first_q, first_d;
   logic          out_valid_q, out_valid_d;
   logic          out_fail_q, out_fail_d;
   logic [W-1:0]  out_row_q, out_row_d;
   logic [W-1:0]  out_col_q, out_col_d;
   logic          busy_q, busy_d;

   logic [N-1:0]   grid_q  [N];
   logic [N-1:0]   grid_d  [N];
   logic [2*W-1:0] path_q  [PATH_LEN];
   logic [2*W-1:0] path_d  [PATH_LEN];
   entry_t         stack_q [STACK_DEPTH];
   entry_t         stack_d [STACK_DEPTH];

   logic   d_ok, r_ok, blocked;
   entry_t push_e, top_e;

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      r_d         = r_q;
      c_d         = c_q;
      idx_d       = idx_q;
      sp_d        = sp_q;
      oidx_d      = oidx_q;
      first_d     = first_q;
      out_valid_d = 1'b0;
      out_fail_d  = 1'b0;
      out_row_d   = '0;
      out_col_d   = '0;
      grid_d      = grid_q;
      path_d      = path_q;
      stack_d     = stack_q;
      d_ok        = 1'b0;
      r_ok        = 1'b0;
      blocked     = 1'b0;
      push_e      = '0;
      top_e       = '0;

      // A row outside LOAD always starts a fresh load: from IDLE this is the
      // normal start, from SOLVE/OUTPUT/FAIL it aborts the current maze.
      if (bus.in_valid && (state_q != S_LOAD)) begin
         grid_d[0] = bus.maze;
         row_cnt_d = W'(1);
         sp_d      = '0;
         state_d   = S_LOAD;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_LOAD: begin
               if (bus.in_valid) begin
                  grid_d[row_cnt_q] = bus.maze;
                  if (row_cnt_q == LAST) begin
                     state_d   = S_SOLVE;
                     row_cnt_d = '0;
                     r_d       = '0;
                     c_d       = '0;
                     idx_d     = '0;
                     sp_d      = '0;
                     first_d   = 1'b1;
                  end else begin
                     row_cnt_d = row_cnt_q + 1'b1;
                  end
               end
            end
            S_SOLVE: begin
               // Visited cells become walls so no cell is entered twice.
               grid_d[r_q][c_q] = 1'b0;
               d_ok    = (r_q != LAST) && grid_q[r_q + 1'b1][c_q];
               r_ok    = (c_q != LAST) && grid_q[r_q][c_q + 1'b1];
               // Only the start cell is checked for being a wall itself; a
               // restored branch cell is walled by its earlier visit.
               blocked = first_q && !grid_q[0][0];
               first_d = 1'b0;
               if ((r_q == LAST) && (c_q == LAST)) begin
                  path_d[idx_q] = {r_q, c_q};
                  state_d       = S_OUTPUT;
                  out_valid_d   = 1'b1;
                  {out_row_d, out_col_d} = path_q[0];
                  oidx_d        = IW'(1);
               end else if ((d_ok || r_ok) && !blocked) begin
                  path_d[idx_q] = {r_q, c_q};
                  idx_d         = idx_q + 1'b1;
                  if (d_ok && r_ok) begin
                     push_e.r       = r_q;
                     push_e.c       = c_q;
                     push_e.idx     = idx_q;
                     stack_d[sp_q]  = push_e;
                     sp_d           = sp_q + 1'b1;
                  end
                  if (d_ok) begin
                     r_d = r_q + 1'b1;
                  end else begin
                     c_d = c_q + 1'b1;
                  end
               end else if (sp_q != '0) begin
                  top_e = stack_q[sp_q - 1'b1];
                  r_d   = top_e.r;
                  c_d   = top_e.c;
                  idx_d = top_e.idx;
                  sp_d  = sp_q - 1'b1;
               end else begin
                  state_d     = S_FAIL;
                  out_valid_d = 1'b1;
                  out_fail_d  = 1'b1;
               end
            end
            S_OUTPUT: begin
               if (oidx_q == PLEN) begin
                  state_d = S_IDLE;
               end else begin
                  out_valid_d = 1'b1;
                  {out_row_d, out_col_d} = path_q[oidx_q];
                  oidx_d = oidx_q + 1'b1;
               end
            end
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         row_cnt_q   <= '0;
         r_q         <= '0;
         c_q         <= '0;
         idx_q       <= '0;
         sp_q        <= '0;
         oidx_q      <= '0;
         first_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_fail_q  <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         r_q         <= r_d;
         c_q         <= c_d;
         idx_q       <= idx_d;
         sp_q        <= sp_d;
         oidx_q      <= oidx_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_fail_q  <= out_fail_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         busy_q      <= busy_d;
      end
   end

   // Maze, path and stack storage carry no reset; the stack pointer alone
   // defines which stack entries are live.
   always_ff @(posedge clk) begin
      grid_q  <= grid_d;
      path_q  <= path_d;
      stack_q <= stack_d;
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_fail  = out_fail_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_col   = out_col_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rim_solver_param.sv
module tb_rim_solver_param;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rim_solver_param_if #(.N(8)) bus8 ();
   rim_solver_param_if #(.N(4)) bus4 ();

   rim_solver_param #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   rim_solver_param #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   int checks   = 0;
   int failures = 0;

   // Expected output stream per DUT, entry = fail*256 + row*16 + col.
   int q8[$];
   int q4[$];
   bit need [2];
   logic [15:0] mz [16];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic bit ov(input bit f);
      return f ? bus4.out_valid : bus8.out_valid;
   endfunction

   function automatic bit bz(input bit f);
      return f ? bus4.busy : bus8.busy;
   endfunction

   function automatic int enc(input bit f);
      if (f) return int'(bus4.out_fail)*256 + int'(bus4.out_row)*16 + int'(bus4.out_col);
      return int'(bus8.out_fail)*256 + int'(bus8.out_row)*16 + int'(bus8.out_col);
   endfunction

   function automatic int qsize(input bit f);
      return f ? q4.size() : q8.size();
   endfunction

   task automatic drive(input bit f, input bit v, input logic [15:0] row);
      if (f) begin
         bus4.in_valid = v;
         bus4.maze     = row[3:0];
      end else begin
         bus8.in_valid = v;
         bus8.maze     = row[7:0];
      end
   endtask

   // Reference: a cell is useful if the goal is reachable from it by
   // down/right moves. The down-first depth-first search ends up following
   // the down-first walk through useful cells.
   function automatic void model(input int n, input bit f);
      bit reach [16][16];
      int r, c;
      for (int rr = n - 1; rr >= 0; rr--) begin
         for (int cc = n - 1; cc >= 0; cc--) begin
            if (mz[rr][cc] == 1'b0)               reach[rr][cc] = 1'b0;
            else if (rr == n - 1 && cc == n - 1)  reach[rr][cc] = 1'b1;
            else reach[rr][cc] = (rr < n - 1 && reach[rr+1][cc]) ||
                                 (cc < n - 1 && reach[rr][cc+1]);
         end
      end
      if (!reach[0][0]) begin
         if (f) q4.push_back(256); else q8.push_back(256);
      end else begin
         r = 0;
         c = 0;
         for (int k = 0; k < 2*n - 1; k++) begin
            if (f) q4.push_back(r*16 + c); else q8.push_back(r*16 + c);
            if (r < n - 1 && reach[r+1][c]) r++;
            else c++;
         end
      end
   endfunction

   task automatic cmp(input bit f);
      int e;
      if (need[f]) chk(f ? "contiguous4" : "contiguous8", int'(ov(f)), 1);
      need[f] = 1'b0;
      if (ov(f)) begin
         if (qsize(f) == 0) begin
            chk(f ? "spurious_valid4" : "spurious_valid8", int'(ov(f)), 0);
         end else begin
            e = f ? q4.pop_front() : q8.pop_front();
            chk(f ? "cell4" : "cell8", enc(f), e);
            need[f] = (e < 256) && (qsize(f) > 0);
         end
      end
   endtask

   initial begin : compare
      forever begin
         @(negedge clk);
         if (rst_n) begin
            cmp(1'b0);
            cmp(1'b1);
         end
      end
   end

   task automatic load_rows(input bit f, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(2, 0)) begin
               drive(f, 1'b0, 16'h0);
               @(posedge clk); #1;
            end
         end
         drive(f, 1'b1, mz[i]);
         @(posedge clk); #1;
         if (i == 0) chk("busy_rise", int'(bz(f)), 1);
      end
      drive(f, 1'b0, 16'h0);
   endtask

   task automatic run_maze(input bit f, input int n, input bit gaps, input int exp_lat);
      int  lat;
      bit  seen;
      load_rows(f, n, gaps);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 2*n*n + 8) begin
         @(negedge clk);
         lat++;
         seen = ov(f);
      end
      chk("first_valid_seen", int'(seen), 1);
      if (seen && exp_lat > 0) chk("first_valid_latency", lat, exp_lat);
      lat = 0;
      while (ov(f) && lat < 4*n) begin
         chk("busy_during_output", int'(bz(f)), 1);
         @(negedge clk);
         lat++;
      end
      chk("busy_fall", int'(bz(f)), 0);
      chk("valid_end", int'(ov(f)), 0);
      chk("expectations_consumed", qsize(f), 0);
      @(posedge clk); #1;
   endtask

   task automatic set_all(input int n, input logic [15:0] v);
      for (int i = 0; i < n; i++) mz[i] = v;
   endtask

   task automatic set_backtrack();
      mz[0] = 16'h00FF;
      for (int i = 1; i <= 4; i++) mz[i] = 16'h0081;
      for (int i = 5; i <= 7; i++) mz[i] = 16'h0080;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0);
      drive(1'b1, 1'b0, 16'h0);
      repeat (3) @(negedge clk);
      for (int f = 0; f < 2; f++) begin
         chk("reset_out_valid", int'(ov(f[0])), 0);
         chk("reset_cell",      enc(f[0]),      0);
         chk("reset_busy",      int'(bz(f[0])), 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Open maze: straight down column 0, then along row 7.
      set_all(8, 16'h00FF);
      model(8, 1'b0);
      chk("pin_open_len", q8.size(), 15);
      chk("pin_open_7",   q8[7],  7*16 + 0);
      chk("pin_open_8",   q8[8],  7*16 + 1);
      chk("pin_open_14",  q8[14], 7*16 + 7);
      run_maze(1'b0, 8, 1'b0, 16);

      // Backtrack maze: column 0 dead-ends at (4,0), path goes along row 0.
      set_backtrack();
      model(8, 1'b0);
      chk("pin_bt_1",  q8[1],  0*16 + 1);
      chk("pin_bt_7",  q8[7],  0*16 + 7);
      chk("pin_bt_8",  q8[8],  1*16 + 7);
      chk("pin_bt_14", q8[14], 7*16 + 7);
      run_maze(1'b0, 8, 1'b0, -1);

      // No path: full wall on row 4.
      set_all(8, 16'h00FF);
      mz[4] = 16'h0000;
      model(8, 1'b0);
      chk("pin_nopath_len", q8.size(), 1);
      chk("pin_nopath_0",   q8[0], 256);
      run_maze(1'b0, 8, 1'b0, -1);

      // Blocked start: failure pulse right after the first SOLVE cycle.
      set_all(8, 16'h00FF);
      mz[0] = 16'h00FE;
      model(8, 1'b0);
      chk("pin_blocked_0", q8[0], 256);
      run_maze(1'b0, 8, 1'b0, 2);

      // Abort mid-SOLVE, then the new load must complete normally.
      set_all(8, 16'h00FF);
      load_rows(1'b0, 8, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("busy_mid_solve", int'(bz(1'b0)), 1);
      set_backtrack();
      model(8, 1'b0);
      run_maze(1'b0, 8, 1'b0, -1);

      // Gapped loads must give the same result as contiguous ones.
      set_backtrack();
      model(8, 1'b0);
      run_maze(1'b0, 8, 1'b1, -1);
      set_all(8, 16'h00FF);
      model(8, 1'b0);
      run_maze(1'b0, 8, 1'b1, -1);

      // Random mazes, N = 8.
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 8; i++) mz[i] = 16'($urandom | $urandom);
         if (t % 4 != 0) mz[0][0] = 1'b1;
         model(8, 1'b0);
         run_maze(1'b0, 8, 1'($urandom_range(1, 0)), -1);
      end

      // N = 4 open maze.
      set_all(4, 16'h000F);
      model(4, 1'b1);
      chk("pin_n4_len", q4.size(), 7);
      chk("pin_n4_3",   q4[3], 3*16 + 0);
      chk("pin_n4_6",   q4[6], 3*16 + 3);
      run_maze(1'b1, 4, 1'b0, 8);

      // Random mazes, N = 4.
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 4; i++) mz[i] = 16'($urandom | $urandom);
         model(4, 1'b1);
         run_maze(1'b1, 4, 1'($urandom_range(1, 0)), -1);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
